// File: rtl/seg_pkg.sv
// Shared constants, conversion state type and helpers for the multiplexed
// seven-segment score display.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'b1011_1111;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // BCD codes A-F cannot come out of the converter; they map to blank.
  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    logic [7:0] r;
    r = SEG_BLANK;
    for (int unsigned k = 0; k < 10; k++)
      if (nib == 4'(k)) r = SEG_DIGIT[k];
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Load/busy handshake and display-control bundle between game logic and the
// score display driver.
interface seg_scan_display_if #(
  parameter int unsigned DIGITS  = 6,
  parameter int unsigned VALUE_W = 20
);
  logic [VALUE_W-1:0] value_i;
  logic               load_i;
  logic               busy_o;
  logic               blank_lz_i;
  logic [DIGITS-1:0]  blink_mask_i;
  logic               overflow_o;

  modport master (output value_i, load_i, blank_lz_i, blink_mask_i,
                  input  busy_o, overflow_o);
  modport slave  (input  value_i, load_i, blank_lz_i, blink_mask_i,
                  output busy_o, overflow_o);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with a one-deep pending load.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned VALUE_W = 20,
  parameter int unsigned DIGITS  = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  job_blank,
  output logic                  job_ovf
);
  localparam int unsigned CW = $clog2(VALUE_W + 1);

  conv_state_t        state_q, state_d;
  logic [VALUE_W-1:0] bin_q;
  logic [CW-1:0]      cnt_q;
  logic               pend_q;
  logic [VALUE_W-1:0] pend_val_q;
  logic               pend_blank_q;
  logic               launch;
  logic [VALUE_W-1:0] launch_val;
  logic               launch_blank;
  logic [4*DIGITS-1:0] adj;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A load arriving in COMMIT is newer than any pending one, so it wins.
  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    launch_val   = value;
    launch_blank = blank_lz;
    unique case (state_q)
      IDLE:   if (start) begin state_d = SHIFT; launch = 1'b1; end
      SHIFT:  if (cnt_q == CW'(VALUE_W - 1)) state_d = COMMIT;
      COMMIT: begin
        if (start) begin
          state_d = SHIFT;
          launch  = 1'b1;
        end else if (pend_q) begin
          state_d      = SHIFT;
          launch       = 1'b1;
          launch_val   = pend_val_q;
          launch_blank = pend_blank_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adj = bcd;
    for (int unsigned d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_q        <= '0;
      bcd          <= '0;
      cnt_q        <= '0;
      job_blank    <= 1'b0;
      job_ovf      <= 1'b0;
      pend_q       <= 1'b0;
      pend_val_q   <= '0;
      pend_blank_q <= 1'b0;
    end else begin
      if (launch) begin
        bin_q     <= launch_val;
        bcd       <= '0;
        cnt_q     <= '0;
        job_blank <= launch_blank;
        job_ovf   <= (64'(launch_val) >= pow10(DIGITS));
      end else if (state_q == SHIFT) begin
        {bcd, bin_q} <= {adj, bin_q} << 1;
        cnt_q        <= cnt_q + CW'(1);
      end
      if (start && state_q != IDLE && !launch) begin
        pend_q       <= 1'b1;
        pend_val_q   <= value;
        pend_blank_q <= blank_lz;
      end else if (launch) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == COMMIT);

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver: BCD conversion, leading-zero
// blanking, overflow dashes, per-digit blink and registered tube scanning.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned VALUE_W     = 20,
  parameter int unsigned SCAN_DUR    = 49_999,
  parameter int unsigned BLINK_SCANS = 250
) (
  input  logic              clk,
  input  logic              rstn,
  seg_scan_display_if.slave bus,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_data
);
  localparam int unsigned SW = $clog2(SCAN_DUR + 1);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned RW = $clog2(BLINK_SCANS + 1);

  if (CLK_FREQ == 0 || DIGITS < 2 || DIGITS > 8 || VALUE_W < 4 || VALUE_W > 27) begin : g_param_check
    $error("seg_scan_display: parameter out of range");
  end

  logic                     conv_done;
  logic [4*DIGITS-1:0]      bcd;
  logic                     job_blank, job_ovf;
  logic [DIGITS-1:0][3:0]   dig_q;
  logic [DIGITS-1:0]        blank_q, lz_blank;
  logic                     ovf_q;
  logic [SW-1:0]            cnt_q;
  logic [IW-1:0]            idx_q, idx_d;
  logic [RW-1:0]            round_q;
  logic                     blink_off_q, phase_d, wrap, scan_next;
  logic [7:0]               pat;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_conv (
    .clk       (clk),
    .rstn      (rstn),
    .start     (bus.load_i),
    .value     (bus.value_i),
    .blank_lz  (bus.blank_lz_i),
    .busy      (bus.busy_o),
    .done      (conv_done),
    .bcd       (bcd),
    .job_blank (job_blank),
    .job_ovf   (job_ovf)
  );

  // Digit 0 is the most significant; the least significant digit never blanks.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      if (bcd[4*(DIGITS-1-i) +: 4] != 4'd0) seen = 1'b1;
      lz_blank[i] = job_blank & ~seen;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dig_q   <= '0;
      blank_q <= '1;
      ovf_q   <= 1'b0;
    end else if (conv_done) begin
      for (int unsigned i = 0; i < DIGITS; i++) dig_q[i] <= bcd[4*(DIGITS-1-i) +: 4];
      blank_q <= lz_blank;
      ovf_q   <= job_ovf;
    end
  end

  assign bus.overflow_o = ovf_q;
  assign scan_next      = (cnt_q == SW'(SCAN_DUR));

  // Pattern is built for the slot being entered so select and data move together.
  always_comb begin
    wrap = 1'b0;
    if (seg_sel == '0)                 idx_d = '0;
    else if (idx_q == IW'(DIGITS - 1)) begin idx_d = '0; wrap = 1'b1; end
    else                               idx_d = idx_q + IW'(1);
    phase_d = blink_off_q ^ (wrap && round_q == RW'(BLINK_SCANS - 1));
    if (ovf_q)                pat = SEG_DASH;
    else if (blank_q[idx_d])  pat = SEG_BLANK;
    else                      pat = seg_of(dig_q[idx_d]);
    if (phase_d && bus.blink_mask_i[idx_d]) pat = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      round_q     <= '0;
      blink_off_q <= 1'b0;
      seg_sel     <= '0;
      seg_data    <= SEG_BLANK;
    end else if (scan_next) begin
      cnt_q       <= '0;
      idx_q       <= idx_d;
      seg_sel     <= DIGITS'(1) << idx_d;
      seg_data    <= pat;
      blink_off_q <= phase_d;
      if (wrap) round_q <= (round_q == RW'(BLINK_SCANS - 1)) ? '0 : round_q + RW'(1);
    end else begin
      cnt_q <= cnt_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed literal expectations and randomized load traffic.
module tb_seg_scan_display;
  localparam int unsigned DIGITS = 4, VALUE_W = 14, SCAN_DUR = 3, BLINK_SCANS = 2;
  localparam int SLOT = SCAN_DUR + 1;

  logic clk = 1'b0;
  logic rstn;
  logic [DIGITS-1:0] seg_sel;
  logic [7:0] seg_data;

  seg_scan_display_if #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) dbus ();

  seg_scan_display #(
    .CLK_FREQ(50_000_000), .DIGITS(DIGITS), .VALUE_W(VALUE_W),
    .SCAN_DUR(SCAN_DUR), .BLINK_SCANS(BLINK_SCANS)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(dbus), .seg_sel(seg_sel), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int e, j_k, j_val, p_val, c_val;
  bit j_act, j_bl, p_act, p_bl, c_valid, c_bl, m_busy, m_ovf;
  logic [DIGITS-1:0] m_sel;
  logic [7:0] m_data;
  int ms, md; bit moff, mld, mbl; int mv; logic [7:0] mpat;

  function automatic int p10(int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] model_pat(int d);
    int place;
    if (!c_valid) return 8'hFF;
    if (m_ovf) return 8'hBF;
    place = p10(DIGITS - 1 - d);
    if (c_bl && d != DIGITS - 1 && c_val < place) return 8'hFF;
    return seg_tab[(c_val / place) % 10];
  endfunction

  function automatic void model_start(int v, bit bl);
    j_act = 1; j_k = 0; j_val = v; j_bl = bl;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e = 0; j_act = 0; j_k = 0; p_act = 0; c_valid = 0; c_val = 0; c_bl = 0;
      m_busy = 0; m_ovf = 0; m_sel = '0; m_data = 8'hFF;
    end else begin
      mld = dbus.load_i; mv = int'(dbus.value_i); mbl = dbus.blank_lz_i;
      e++;
      if (e % SLOT == 0) begin
        ms = e / SLOT - 1;
        md = ms % DIGITS;
        moff = ((ms / DIGITS) / BLINK_SCANS) % 2 == 1;
        mpat = model_pat(md);
        if (moff && dbus.blink_mask_i[md]) mpat = 8'hFF;
        m_sel = DIGITS'(1 << md);
        m_data = mpat;
      end
      if (j_act) begin
        j_k++;
        if (j_k == VALUE_W + 1) begin
          c_valid = 1; c_val = j_val; c_bl = j_bl; m_ovf = (j_val >= p10(DIGITS));
          if (mld) model_start(mv, mbl);
          else if (p_act) model_start(p_val, p_bl);
          else j_act = 0;
          p_act = 0;
        end else if (mld) begin
          p_act = 1; p_val = mv; p_bl = mbl;
        end
      end else if (mld) begin
        model_start(mv, mbl);
      end
      m_busy = j_act;
    end
  end

  always @(negedge clk) begin
    check("seg_sel", 32'(seg_sel), 32'(m_sel));
    check("seg_data", 32'(seg_data), 32'(m_data));
    check("busy_o", 32'(dbus.busy_o), 32'(m_busy));
    check("overflow_o", 32'(dbus.overflow_o), 32'(m_ovf));
  end

  // Length of the most recent contiguous busy_o run.
  int run = 0, last_run = 0;
  always @(negedge clk) begin
    if (dbus.busy_o) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input int v, input bit bl);
    @(posedge clk); #1;
    dbus.value_i = VALUE_W'(v); dbus.blank_lz_i = bl; dbus.load_i = 1'b1;
    @(posedge clk); #1;
    dbus.load_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dbus.busy_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("busy_timeout", 32'(dbus.busy_o), 32'd0);
    @(negedge clk);
  endtask

  task automatic read_digits(output logic [31:0] got);
    got = '1;
    repeat (SLOT * DIGITS) @(negedge clk);
    for (int d = 0; d < DIGITS; d++) begin
      int n = 0;
      while (seg_sel !== DIGITS'(1 << d) && n < 64) begin @(negedge clk); n++; end
      got[8*(DIGITS-1-d) +: 8] = seg_data;
    end
  endtask

  logic [31:0] got;
  int seen_on, seen_off, bad_other, busy_after;

  initial begin
    rstn = 1'b1;
    dbus.load_i = 1'b0; dbus.value_i = '0; dbus.blank_lz_i = 1'b0; dbus.blink_mask_i = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(seg_sel), 32'h0);
    check("rst_data", 32'(seg_data), 32'hFF);
    check("rst_busy", 32'(dbus.busy_o), 32'h0);
    check("rst_ovf", 32'(dbus.overflow_o), 32'h0);
    @(posedge clk); #1 rstn = 1'b1;

    do_load(1234, 1'b0);
    wait_idle();
    check("busy_len_1234", 32'(last_run), 32'd15);
    read_digits(got);
    check("digits_1234", got, 32'hF9A4B099);

    do_load(7, 1'b1);   wait_idle(); read_digits(got);
    check("digits_7_lz", got, 32'hFFFFFFF8);
    do_load(0, 1'b1);   wait_idle(); read_digits(got);
    check("digits_0_lz", got, 32'hFFFFFFC0);

    do_load(10000, 1'b1); wait_idle();
    check("ovf_10000", 32'(dbus.overflow_o), 32'h1);
    read_digits(got);
    check("digits_10000", got, 32'hBFBFBFBF);
    do_load(9999, 1'b0); wait_idle();
    check("ovf_9999", 32'(dbus.overflow_o), 32'h0);
    read_digits(got);
    check("digits_9999", got, 32'h90909090);

    do_load(5, 1'b0);
    do_load(12, 1'b0);
    @(posedge clk);
    do_load(34, 1'b0);
    wait_idle();
    check("busy_len_5_34", 32'(last_run), 32'd30);
    read_digits(got);
    check("digits_34", got, 32'hC0C0B099);

    do_load(1234, 1'b0); wait_idle();
    dbus.blink_mask_i = 4'b0001;
    seen_on = 0; seen_off = 0; bad_other = 0;
    repeat (200) begin
      @(negedge clk);
      if (seg_sel == 4'b0001 && seg_data == 8'hF9) seen_on++;
      if (seg_sel == 4'b0001 && seg_data == 8'hFF) seen_off++;
      if (seg_sel == 4'b1000 && seg_data != 8'h99) bad_other++;
    end
    check("blink_on_seen", 32'(seen_on > 0), 32'd1);
    check("blink_off_seen", 32'(seen_off > 0), 32'd1);
    check("blink_steady_d3", 32'(bad_other), 32'd0);
    dbus.blink_mask_i = '0;

    do_load(4321, 1'b0);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("midrst_sel", 32'(seg_sel), 32'h0);
    check("midrst_data", 32'(seg_data), 32'hFF);
    check("midrst_busy", 32'(dbus.busy_o), 32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    busy_after = 0;
    repeat (30) begin @(negedge clk); if (dbus.busy_o) busy_after++; end
    check("midrst_no_commit_busy", 32'(busy_after), 32'd0);
    read_digits(got);
    check("midrst_dark", got, 32'hFFFFFFFF);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      dbus.load_i = ($urandom % 6 == 0);
      dbus.value_i = ($urandom % 4 == 0) ? VALUE_W'($urandom_range(9990, 16383))
                                         : VALUE_W'($urandom % 10000);
      dbus.blank_lz_i = $urandom % 2;
      if (i % 50 == 0) dbus.blink_mask_i = DIGITS'($urandom);
    end
    dbus.load_i = 1'b0;
    wait_idle();
    repeat (2 * SLOT * DIGITS) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
